gouram_trace_sequencer: RTL

In-order sequencer for Gouram trace records. It allocates one `trace_format` slot per fetched instruction, tagged by buffer index. It merges out-of-order ID/EX/WB stage-completion updates into that slot. It retires completed records strictly in fetch order over a valid/ready stream. It sits between the per-stage trace monitors and the trace output/packing logic.

---
 rtl/gouram_trace_sequencer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/gouram_trace_sequencer.sv
// ---------------------------------------------------------------------------
// gouram_trace_sequencer
//
// In-order sequencer for Gouram trace records. Each fetched instruction gets
// one trace_format slot, addressed by its buffer index (tag). The per-stage
// trace monitors merge ID/EX/WB completion updates into that slot in any
// order. Completed records are then retired strictly in fetch order over a
// valid/ready stream towards the trace output/packing logic.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   alloc_req           new instruction fetched; request a slot
//   alloc_instr/addr    instruction word and address for the new slot
//   alloc_pass_through  copied into the record's pass_through bit
//   alloc_if_start/end  IF stage time_start / time_end
//   alloc_gnt           slot granted this cycle (combinational)
//   alloc_tag           index of the granted slot (current write pointer)
//   upd_valid           stage-completion update strobe
//   upd_tag             slot being updated
//   upd_stage           0=ID, 1=EX, 2=WB, 3=reserved
//   upd_start/end       stage time_start / time_end
//   upd_mem_addr        EX memory address (ignored for other stages)
//   flush               discard every slot at the next edge
//   out_valid           head record is complete
//   out_ready           consumer accepts the head record
//   out_record          head record (all-zero while out_valid is low)
//   count               number of occupied slots
//   upd_err             sticky: update to an unallocated slot, with the
//                       reserved stage code, or to a slot retiring that cycle
// ---------------------------------------------------------------------------

package gouram_trace_pkg;

    typedef struct packed {
        logic [31:0] time_start;
        logic [31:0] time_end;
    } stage_time_t;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] addr;
        logic        pass_through;
        stage_time_t if_data;
        stage_time_t id_data;
        stage_time_t ex_data;
        logic [31:0] mem_addr;
        stage_time_t mem_access_req;
        stage_time_t mem_access_res;
        stage_time_t wb_data;
    } trace_format;

    localparam logic [1:0] STAGE_ID   = 2'd0;
    localparam logic [1:0] STAGE_EX   = 2'd1;
    localparam logic [1:0] STAGE_WB   = 2'd2;
    localparam logic [1:0] STAGE_RSVD = 2'd3;

endpackage

module gouram_trace_sequencer
    import gouram_trace_pkg::*;
#(
    parameter int TRACE_BUFFER_SIZE = 64,
    parameter int DEPTH             = TRACE_BUFFER_SIZE,
    parameter int TAG_W             = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              alloc_req,
    input  logic [31:0]       alloc_instr,
    input  logic [31:0]       alloc_addr,
    input  logic              alloc_pass_through,
    input  logic [31:0]       alloc_if_start,
    input  logic [31:0]       alloc_if_end,
    output logic              alloc_gnt,
    output logic [TAG_W-1:0]  alloc_tag,

    input  logic              upd_valid,
    input  logic [TAG_W-1:0]  upd_tag,
    input  logic [1:0]        upd_stage,
    input  logic [31:0]       upd_start,
    input  logic [31:0]       upd_end,
    input  logic [31:0]       upd_mem_addr,

    input  logic              flush,

    output logic              out_valid,
    input  logic              out_ready,
    output trace_format       out_record,

    output logic [TAG_W:0]    count,
    output logic              upd_err
);

    localparam logic [TAG_W:0] L_FULL = (TAG_W + 1)'(DEPTH);

    // Control state
    logic [TAG_W-1:0] r_wp;
    logic [TAG_W-1:0] r_rp;
    logic [TAG_W:0]   r_count;
    logic [DEPTH-1:0] r_alloc;
    logic [DEPTH-1:0] r_done;
    logic             r_upd_err;

    // Record payload; never reset, only ever read behind the alloc/done flags
    trace_format      r_mem [DEPTH];

    logic             w_full;
    logic             w_grant;
    logic             w_out_valid;
    logic             w_retire;
    logic             w_upd_seen;
    logic             w_upd_bad;
    logic             w_upd_ok;
    trace_format      w_new_rec;
    stage_time_t      w_upd_time;

    // The full check deliberately uses the registered count, so a slot freed
    // by a retire in this cycle only becomes grantable in the next cycle.
    assign w_full      = (r_count == L_FULL);
    assign w_grant     = alloc_req && !w_full && !flush;
    assign w_out_valid = r_alloc[r_rp] && r_done[r_rp];
    assign w_retire    = w_out_valid && out_ready && !flush;

    // An update racing the retirement of its own slot would be lost with the
    // slot, so it is treated like any other rejected update.
    assign w_upd_seen  = upd_valid && !flush;
    assign w_upd_bad   = (upd_stage == STAGE_RSVD)
                      || !r_alloc[upd_tag]
                      || (w_retire && (upd_tag == r_rp));
    assign w_upd_ok    = w_upd_seen && !w_upd_bad;

    assign w_upd_time.time_start = upd_start;
    assign w_upd_time.time_end   = upd_end;

    // Freshly allocated record: IF information loaded, everything else zero.
    always_comb begin
        w_new_rec                    = '0;
        w_new_rec.instruction        = alloc_instr;
        w_new_rec.addr               = alloc_addr;
        w_new_rec.pass_through       = alloc_pass_through;
        w_new_rec.if_data.time_start = alloc_if_start;
        w_new_rec.if_data.time_end   = alloc_if_end;
    end

    // Pointers, occupancy and per-slot flags. A grant targets wp, which is
    // always a free slot, so it can never collide with the retire at rp or
    // with an accepted update (which needs an allocated slot).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_alloc <= '0;
            r_done  <= '0;
        end else if (flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_alloc <= '0;
            r_done  <= '0;
        end else begin
            if (w_grant) begin
                r_alloc[r_wp] <= 1'b1;
                r_done[r_wp]  <= 1'b0;
                r_wp          <= r_wp + 1'b1;
            end
            if (w_upd_ok && (upd_stage == STAGE_WB)) begin
                r_done[upd_tag] <= 1'b1;
            end
            if (w_retire) begin
                r_alloc[r_rp] <= 1'b0;
                r_done[r_rp]  <= 1'b0;
                r_rp          <= r_rp + 1'b1;
            end
            case ({w_grant, w_retire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Error flag survives flush; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upd_err <= 1'b0;
        end else if (w_upd_seen && w_upd_bad) begin
            r_upd_err <= 1'b1;
        end
    end

    // Payload writes: allocation loads the whole slot, stage updates merge
    // only their own fields so they can arrive in any order.
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_mem[r_wp] <= w_new_rec;
        end
        if (w_upd_ok) begin
            case (upd_stage)
                STAGE_ID: begin
                    r_mem[upd_tag].id_data <= w_upd_time;
                end
                STAGE_EX: begin
                    r_mem[upd_tag].ex_data  <= w_upd_time;
                    r_mem[upd_tag].mem_addr <= upd_mem_addr;
                end
                STAGE_WB: begin
                    r_mem[upd_tag].wb_data <= w_upd_time;
                end
                default: begin
                end
            endcase
        end
    end

    assign alloc_gnt  = w_grant;
    assign alloc_tag  = r_wp;
    assign out_valid  = w_out_valid;
    assign out_record = w_out_valid ? r_mem[r_rp] : '0;
    assign count      = r_count;
    assign upd_err    = r_upd_err;

endmodule
